// File: rtl/nabp_swap_control_pkg.sv
// nabp_swap_control_pkg: shared sizes and sequencer states for the NABP swap/state-control slice.
package nabp_swap_control_pkg;
    localparam int kDefNoOfAngles    = 180;
    localparam int kDefNoOfLineCnts  = 8;
    localparam int kDefAngleLength   = 8;
    localparam int kDefLineCntLength = 3;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/nabp_swap_control_if.sv
// nabp_swap_control_if: request/assignment/swap bundle between the sequencer and state controls A and B.
interface nabp_swap_control_if
    import nabp_swap_control_pkg::*;
#(
    parameter int kAngleLength   = kDefAngleLength,
    parameter int kLineCntLength = kDefLineCntLength
);
    logic                      a_next_itr, b_next_itr;
    logic                      a_swap_ready, b_swap_ready;
    logic                      sw_swap;
    logic [kAngleLength-1:0]   a_angle, b_angle;
    logic [kLineCntLength-1:0] a_line_cnt, b_line_cnt;
    logic                      a_valid, b_valid;
    modport master (
        output a_next_itr, b_next_itr, a_swap_ready, b_swap_ready,
        input  sw_swap, a_angle, b_angle, a_line_cnt, b_line_cnt, a_valid, b_valid
    );
    modport slave (
        input  a_next_itr, b_next_itr, a_swap_ready, b_swap_ready,
        output sw_swap, a_angle, b_angle, a_line_cnt, b_line_cnt, a_valid, b_valid
    );
endinterface

// File: rtl/nabp_iteration_counter.sv
// nabp_iteration_counter: (line_cnt, angle) iterator, angle fastest, advancing by one or two per cycle.
module nabp_iteration_counter
    import nabp_swap_control_pkg::*;
#(
    parameter  int kNoOfAngles    = kDefNoOfAngles,
    parameter  int kNoOfLineCnts  = kDefNoOfLineCnts,
    parameter  int kAngleLength   = kDefAngleLength,
    parameter  int kLineCntLength = kDefLineCntLength,
    localparam int kTotal         = kNoOfAngles * kNoOfLineCnts,
    localparam int kRemW          = $clog2(kTotal + 1)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      clear,
    input  logic                      advance1,
    input  logic                      advance2,
    output logic [kAngleLength-1:0]   angle,
    output logic [kLineCntLength-1:0] line_cnt,
    output logic [kAngleLength-1:0]   next_angle,
    output logic [kLineCntLength-1:0] next_line_cnt,
    output logic [kRemW-1:0]          remaining,
    output logic                      exhausted
);
    typedef logic [kLineCntLength+kAngleLength-1:0] pos_t;

    function automatic pos_t step(input pos_t p);
        logic [kLineCntLength-1:0] l;
        logic [kAngleLength-1:0]   a;
        {l, a} = p;
        if (a != kAngleLength'(kNoOfAngles - 1)) return {l, a + kAngleLength'(1)};
        return {(l == kLineCntLength'(kNoOfLineCnts - 1)) ? kLineCntLength'(0) : l + kLineCntLength'(1),
                kAngleLength'(0)};
    endfunction

    pos_t nxt, nxt2;

    assign nxt                         = step({line_cnt, angle});
    assign nxt2                        = step(nxt);
    assign {next_line_cnt, next_angle} = nxt;
    assign exhausted                   = remaining == '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n || clear) begin
            {line_cnt, angle} <= '0;
            remaining         <= kRemW'(kTotal);
        end else if (advance2) begin
            {line_cnt, angle} <= nxt2;
            remaining         <= remaining - kRemW'(2);
        end else if (advance1) begin
            {line_cnt, angle} <= nxt;
            remaining         <= remaining - kRemW'(1);
        end
    end
endmodule

// File: rtl/nabp_swap_control.sv
// nabp_swap_control: hands (line_cnt, angle) iterations to state controls A/B and broadcasts their swap pulse.
module nabp_swap_control
    import nabp_swap_control_pkg::*;
#(
    parameter  int kNoOfAngles    = kDefNoOfAngles,
    parameter  int kNoOfLineCnts  = kDefNoOfLineCnts,
    parameter  int kAngleLength   = kDefAngleLength,
    parameter  int kLineCntLength = kDefLineCntLength,
    localparam int kRemW          = $clog2(kNoOfAngles * kNoOfLineCnts + 1)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start,
    output logic done,
    nabp_swap_control_if.slave ctl
);
    state_t                    state, state_n;
    logic [kAngleLength-1:0]   angle, next_angle;
    logic [kLineCntLength-1:0] line_cnt, next_line_cnt;
    logic [kRemW-1:0]          remaining;
    logic                      exhausted, blocked, both_ready, grant_ok, b_ok, adv1, adv2, issue;

    nabp_iteration_counter #(
        .kNoOfAngles(kNoOfAngles), .kNoOfLineCnts(kNoOfLineCnts),
        .kAngleLength(kAngleLength), .kLineCntLength(kLineCntLength)
    ) u_itr (
        .clk, .reset_n, .clear(state == IDLE && start), .advance1(adv1), .advance2(adv2),
        .angle, .line_cnt, .next_angle, .next_line_cnt, .remaining, .exhausted
    );

    always_comb begin
        both_ready = ctl.a_swap_ready && ctl.b_swap_ready;
        grant_ok   = state == RUN && !exhausted;
        b_ok       = grant_ok && (!ctl.a_next_itr || remaining > kRemW'(1));
        adv2       = grant_ok && ctl.a_next_itr && ctl.b_next_itr && remaining > kRemW'(1);
        adv1       = grant_ok && (ctl.a_next_itr || ctl.b_next_itr) && !adv2;
        issue      = both_ready && !blocked &&
                     (state == RUN || (state == DRAIN && (ctl.a_valid || ctl.b_valid)));
        state_n    = state == IDLE  ? (start ? RUN : IDLE) :
                     state == RUN   ? (exhausted ? DRAIN : RUN) :
                     state == DRAIN ? (!ctl.a_valid && !ctl.b_valid ? DONE : DRAIN) : IDLE;
    end

    assign done = state == DONE;

    // blocked holds off a repeat swap until the controllers have left fill-done at least once
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            blocked        <= 1'b0;
            ctl.sw_swap    <= 1'b0;
            ctl.a_valid    <= 1'b0;
            ctl.b_valid    <= 1'b0;
            ctl.a_angle    <= '0;
            ctl.b_angle    <= '0;
            ctl.a_line_cnt <= '0;
            ctl.b_line_cnt <= '0;
        end else begin
            state       <= state_n;
            blocked     <= issue || (blocked && both_ready && state != IDLE);
            ctl.sw_swap <= issue;
            if (ctl.a_next_itr) begin
                ctl.a_valid <= grant_ok;
                if (grant_ok) {ctl.a_line_cnt, ctl.a_angle} <= {line_cnt, angle};
            end
            if (ctl.b_next_itr) begin
                ctl.b_valid <= b_ok;
                if (b_ok) {ctl.b_line_cnt, ctl.b_angle} <= ctl.a_next_itr ? {next_line_cnt, next_angle}
                                                                          : {line_cnt, angle};
            end
        end
    end
endmodule

// File: tb/tb_nabp_swap_control.sv
// tb_nabp_swap_control: directed table, corner sequences and random traffic against a queue-based model.
module tb_nabp_swap_control;
    import nabp_swap_control_pkg::*;

    localparam int NA = 4;
    localparam int NL = 2;

    logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, done;
    nabp_swap_control_if #(.kAngleLength(8), .kLineCntLength(3)) ctl();
    nabp_swap_control #(.kNoOfAngles(NA), .kNoOfLineCnts(NL), .kAngleLength(8), .kLineCntLength(3)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .done(done), .ctl(ctl.slave)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // model: mode 0 idle, 1 run, 2 drain, 3 done; q holds iterations still to hand out (lc*NA+angle)
    int ms, q[$];
    int m_av, m_bv, m_aa, m_al, m_ba, m_bl, m_sw;
    bit armed;

    task automatic model_reset();
        ms = 0; q.delete();
        m_av = 0; m_bv = 0; m_aa = 0; m_al = 0; m_ba = 0; m_bl = 0; m_sw = 0;
        armed = 1'b1;
    endtask

    task automatic model_edge(input bit a, input bit b, input bit ar, input bit br, input bit st);
        int  pst = ms, it;
        bit  pav = m_av[0], pbv = m_bv[0], pempty = q.size() == 0, both = ar && br, iss;
        iss = both && armed && (pst == 1 || (pst == 2 && (pav || pbv)));
        if (a) begin
            if (pst == 1 && q.size() > 0) begin
                it = q.pop_front(); m_aa = it % NA; m_al = it / NA; m_av = 1;
            end else m_av = 0;
        end
        if (b) begin
            if (pst == 1 && q.size() > 0) begin
                it = q.pop_front(); m_ba = it % NA; m_bl = it / NA; m_bv = 1;
            end else m_bv = 0;
        end
        m_sw  = iss;
        armed = iss ? 1'b0 : (!both || pst == 0) ? 1'b1 : armed;
        if (pst == 0 && st) begin
            ms = 1; q.delete();
            for (int i = 0; i < NA * NL; i++) q.push_back(i);
        end else if (pst == 1 && pempty) ms = 2;
        else if (pst == 2 && !pav && !pbv) ms = 3;
        else if (pst == 3) ms = 0;
    endtask

    task automatic check_all(input string t);
        chk({t, ".a_valid"}, ctl.a_valid, m_av);
        chk({t, ".b_valid"}, ctl.b_valid, m_bv);
        chk({t, ".a_angle"}, ctl.a_angle, m_aa);
        chk({t, ".a_line_cnt"}, ctl.a_line_cnt, m_al);
        chk({t, ".b_angle"}, ctl.b_angle, m_ba);
        chk({t, ".b_line_cnt"}, ctl.b_line_cnt, m_bl);
        chk({t, ".sw_swap"}, ctl.sw_swap, m_sw);
        chk({t, ".done"}, done, ms == 3);
    endtask

    task automatic step(input string t, input bit a, input bit b, input bit ar, input bit br, input bit st);
        ctl.a_next_itr = a; ctl.b_next_itr = b;
        ctl.a_swap_ready = ar; ctl.b_swap_ready = br;
        start = st;
        @(posedge clk);
        model_edge(a, b, ar, br, st);
        #1;
        check_all(t);
    endtask

    typedef struct {
        bit a, b, ar, br, st;
        bit av, bv;
        int aa, al, ba, bl;
        bit sw, dn;
    } vec_t;
    vec_t tbl[14];

    int dones;

    initial begin
        ctl.a_next_itr = 0; ctl.b_next_itr = 0; ctl.a_swap_ready = 0; ctl.b_swap_ready = 0;
        model_reset();
        #2;
        check_all("reset");
        #10 reset_n = 1'b1;

        // a b ar br st | av bv aa al ba bl sw dn : flush, alternating, paired grants, drain, done
        tbl[0]  = '{0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        tbl[2]  = '{1, 1, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0};
        tbl[3]  = '{0, 0, 1, 1, 0, 1, 1, 0, 0, 1, 0, 1, 0};
        tbl[4]  = '{1, 0, 0, 0, 0, 1, 1, 2, 0, 1, 0, 0, 0};
        tbl[5]  = '{0, 1, 0, 0, 0, 1, 1, 2, 0, 3, 0, 0, 0};
        tbl[6]  = '{1, 1, 0, 0, 0, 1, 1, 0, 1, 1, 1, 0, 0};
        tbl[7]  = '{1, 1, 0, 0, 0, 1, 1, 2, 1, 3, 1, 0, 0};
        tbl[8]  = '{0, 0, 0, 0, 0, 1, 1, 2, 1, 3, 1, 0, 0};
        tbl[9]  = '{0, 0, 1, 1, 0, 1, 1, 2, 1, 3, 1, 1, 0};
        tbl[10] = '{1, 1, 0, 0, 0, 0, 0, 2, 1, 3, 1, 0, 0};
        tbl[11] = '{0, 0, 1, 1, 0, 0, 0, 2, 1, 3, 1, 0, 1};
        tbl[12] = '{0, 0, 1, 1, 0, 0, 0, 2, 1, 3, 1, 0, 0};
        tbl[13] = '{1, 0, 1, 1, 0, 0, 0, 2, 1, 3, 1, 0, 0};
        foreach (tbl[i]) begin
            step("tbl_model", tbl[i].a, tbl[i].b, tbl[i].ar, tbl[i].br, tbl[i].st);
            chk($sformatf("tbl%0d.a_valid", i), ctl.a_valid, tbl[i].av);
            chk($sformatf("tbl%0d.b_valid", i), ctl.b_valid, tbl[i].bv);
            chk($sformatf("tbl%0d.a_pos", i), {ctl.a_line_cnt, ctl.a_angle}, {3'(tbl[i].al), 8'(tbl[i].aa)});
            chk($sformatf("tbl%0d.b_pos", i), {ctl.b_line_cnt, ctl.b_angle}, {3'(tbl[i].bl), 8'(tbl[i].ba)});
            chk($sformatf("tbl%0d.sw_swap", i), ctl.sw_swap, tbl[i].sw);
            chk($sformatf("tbl%0d.done", i), done, tbl[i].dn);
        end

        // paired request with only (1,3) left: A valid, B invalid, then drain to done
        step("last", 0, 0, 1, 1, 1);
        step("last", 0, 0, 1, 1, 0);
        for (int i = 0; i < NA * NL - 1; i++) step("last", 1, 0, 0, 0, 0);
        step("last", 1, 1, 0, 0, 0);
        chk("last.a_valid", ctl.a_valid, 1);
        chk("last.a_pos", {ctl.a_line_cnt, ctl.a_angle}, {3'd1, 8'd3});
        chk("last.b_valid", ctl.b_valid, 0);
        step("last", 0, 0, 0, 0, 0);
        step("last", 0, 0, 1, 1, 0);
        chk("last.drain_swap", ctl.sw_swap, 1);
        step("last", 1, 1, 0, 0, 0);
        step("last", 0, 0, 0, 0, 0);
        chk("last.done", done, 1);
        step("last", 0, 0, 1, 1, 0);

        // start during RUN ignored; async reset with iterator at (1,1); restart from (0,0)
        step("rst", 0, 0, 1, 1, 1);
        step("rst", 0, 0, 1, 1, 0);
        step("rst", 1, 1, 0, 0, 0);
        step("rst", 1, 1, 0, 0, 0);
        step("rst", 1, 0, 0, 0, 1);
        chk("rst.ignored_start", {ctl.a_line_cnt, ctl.a_angle}, {3'd1, 8'd0});
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check_all("rst.async");
        @(negedge clk) reset_n = 1'b1;
        step("rst", 0, 0, 1, 1, 1);
        step("rst", 0, 0, 1, 1, 0);
        chk("rst.flush_swap", ctl.sw_swap, 1);
        step("rst", 1, 0, 0, 0, 0);
        chk("rst.first_valid", ctl.a_valid, 1);
        chk("rst.first_pos", {ctl.a_line_cnt, ctl.a_angle}, 0);

        dones = 0;
        for (int i = 0; i < 2000; i++) begin
            step("rand", $urandom_range(99) < 30, $urandom_range(99) < 30,
                 $urandom_range(1), $urandom_range(1), $urandom_range(99) < 5);
            dones += done;
        end
        chk("rand.done_seen", dones > 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
